// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// default widths and the even-parity function used by the optional parity column.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    localparam int DM_ADDR_W    = 8;
    localparam int DM_DATA_W    = 16;
    // Widest data word dm_parity() accepts; callers zero-pad narrower words.
    localparam int DM_PAR_MAX_W = 64;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic dm_parity(input logic [DM_PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word array with write enable and registered read.
// With DATA_MEM_PARITY_EN defined each word carries an even-parity bit checked on read.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W,
    parameter int DEPTH  = 200
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              par_err
);

`ifdef DATA_MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] word_reg;
    logic [WORD_W-1:0] word_next;

    // Contents are deliberately not reset; the read register only updates on access.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= word_next;
            end
            word_reg <= mem[addr];
        end
    end

`ifdef DATA_MEM_PARITY_EN
    logic [DM_PAR_MAX_W-1:0] wpad;
    logic [DM_PAR_MAX_W-1:0] rpad;

    always_comb begin
        wpad = '0;
        wpad[DATA_W-1:0] = wdata;
        rpad = '0;
        rpad[DATA_W-1:0] = word_reg[DATA_W-1:0];
    end

    assign word_next = {dm_parity(wpad), wdata};
    assign par_err   = word_reg[DATA_W] != dm_parity(rpad);
`else
    assign word_next = wdata;
    assign par_err   = 1'b0;
`endif

    assign rdata = word_reg[DATA_W-1:0];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_CYCLES wait states, then a held response.
// Optional even-parity checking is enabled by defining DATA_MEM_PARITY_EN.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_W      = DM_ADDR_W,
    parameter int DATA_W      = DM_DATA_W,
    parameter int DEPTH       = 200,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    dm_state_t state_reg;
    dm_state_t state_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              fill_reg;
    logic              fill_we_reg;
    logic              fill_oor_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;

    logic              access;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              in_range;
    logic              arr_en;
    logic [DATA_W-1:0] arr_rdata;
    logic              arr_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // With no wait states the array is driven straight from the request on the accept edge.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        access     = 1'b0;
        acc_we     = we_reg;
        acc_addr   = addr_reg;
        acc_wdata  = wdata_reg;
        case (state_reg)
            IDLE: begin
                acc_we    = req_we;
                acc_addr  = req_addr;
                acc_wdata = req_wdata;
                if (req_valid) begin
                    cnt_next = WAIT_L;
                    if (WAIT_L == 4'd0) begin
                        access     = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_reg && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_range = {1'b0, acc_addr} < DEPTH_L;
    assign arr_en   = access && in_range;

    data_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .en      (arr_en),
        .we      (acc_we),
        .addr    (acc_addr),
        .wdata   (acc_wdata),
        .rdata   (arr_rdata),
        .par_err (arr_par_err)
    );

    // The array read register lands on the access edge; the response flops
    // capture it one edge later, which sets the WAIT_CYCLES+1 latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            fill_reg      <= 1'b0;
            fill_we_reg   <= 1'b0;
            fill_oor_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && req_valid) begin
                we_reg    <= req_we;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            fill_reg <= access;
            if (access) begin
                fill_we_reg  <= acc_we;
                fill_oor_reg <= !in_range;
            end
            if (fill_reg) begin
                rsp_valid_reg <= 1'b1;
                rsp_rdata_reg <= (fill_we_reg || fill_oor_reg) ? '0 : arr_rdata;
                rsp_err_reg   <= fill_oor_reg || (!fill_we_reg && arr_par_err);
            end else if (rsp_valid_reg && rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign req_ready = rst_n && (state_reg == IDLE);
    assign busy      = state_reg != IDLE;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses 0.
module tb_data_mem_responder;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 200;
    localparam int WC    = 2;

`ifdef DATA_MEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_wdata [2];
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_rdata [2];
    logic [1:0]    rsp_err;
    logic [1:0]    busy;

    int errors = 0;
    int checks = 0;

    exp_t          sb [$];
    logic [DW-1:0] model_mem [0:1][0:255];
    bit            model_bad [0:1][0:255];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    // One complete transaction; hold>0 keeps rsp_ready low for that many cycles in RESP
    // while pulsing a stray store that must be ignored.
    task automatic run_txn(input int inst, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int hold);
        exp_t          e;
        exp_t          got;
        int            lat;
        int            guard;
        int            exp_lat;
        logic [DW-1:0] held;
        exp_lat = (inst == 0) ? WC + 1 : 1;
        if (int'(addr) >= DEPTH) begin
            e.data = '0;
            e.err  = 1'b1;
        end else if (we) begin
            model_mem[inst][addr] = wdata;
            model_bad[inst][addr] = 1'b0;
            e.data = '0;
            e.err  = 1'b0;
        end else begin
            e.data = model_mem[inst][addr];
            e.err  = PAR_EN && model_bad[inst][addr];
        end
        sb.push_back(e);

        @(negedge clk);
        rsp_ready[inst] = (hold == 0);
        req_valid[inst] = 1'b1;
        req_we[inst]    = we;
        req_addr[inst]  = addr;
        req_wdata[inst] = wdata;
        guard = 0;
        while (req_ready[inst] !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL accept_timeout inst=%0d req_ready=%b required 1", inst, req_ready[inst]);
        end
        @(posedge clk);
        #1;
        req_valid[inst] = 1'b0;

        lat = 0;
        while (rsp_valid[inst] !== 1'b1 && lat < 40) begin
            checks++;
            if (req_ready[inst] !== ~busy[inst]) begin
                errors++;
                $display("FAIL ready_vs_busy inst=%0d req_ready=%b busy=%b required req_ready=~busy",
                         inst, req_ready[inst], busy[inst]);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency inst=%0d got=%0d required=%0d", inst, lat, exp_lat);
        end

        got = sb.pop_front();
        checks++;
        if (rsp_rdata[inst] !== got.data) begin
            errors++;
            $display("FAIL rsp_rdata inst=%0d addr=%0d got=%h required=%h", inst, addr, rsp_rdata[inst], got.data);
        end
        checks++;
        if (rsp_err[inst] !== got.err) begin
            errors++;
            $display("FAIL rsp_err inst=%0d addr=%0d got=%b required=%b", inst, addr, rsp_err[inst], got.err);
        end

        if (hold > 0) begin
            held = rsp_rdata[inst];
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                req_valid[inst] = (i % 2 == 0);
                req_we[inst]    = 1'b1;
                req_wdata[inst] = 16'hDEAD;
                @(posedge clk);
                #1;
                checks++;
                if (rsp_valid[inst] !== 1'b1 || rsp_rdata[inst] !== held || req_ready[inst] !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_hold cycle=%0d valid=%b rdata=%h ready=%b required valid=1 rdata=%h ready=0",
                             i, rsp_valid[inst], rsp_rdata[inst], req_ready[inst], held);
                end
            end
            @(negedge clk);
            req_valid[inst] = 1'b0;
            rsp_ready[inst] = 1'b1;
        end

        @(posedge clk);
        #1;
        checks++;
        if (busy[inst] !== 1'b0 || rsp_valid[inst] !== 1'b0 || req_ready[inst] !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake inst=%0d busy=%b rsp_valid=%b req_ready=%b required 0/0/1",
                     inst, busy[inst], rsp_valid[inst], req_ready[inst]);
        end
        $display("txn inst=%0d we=%0b addr=%0d wdata=%h rdata=%h err=%0b lat=%0d hold=%0d",
                 inst, we, addr, wdata, rsp_rdata[inst], rsp_err[inst], lat, hold);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (req_ready[i] !== 1'b0 || busy[i] !== 1'b0 || rsp_valid[i] !== 1'b0 ||
                rsp_rdata[i] !== '0 || rsp_err[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst=%0d ready=%b busy=%b valid=%b rdata=%h err=%b required all 0",
                         i, req_ready[i], busy[i], rsp_valid[i], rsp_rdata[i], rsp_err[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (req_ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset inst=%0d got=%b required 1", i, req_ready[i]);
            end
        end
        $display("txn reset done");
    endtask

    task automatic test_store_load();
        run_txn(0, 1'b1, 8'd5, 16'hBEEF, 0);
        run_txn(0, 1'b0, 8'd5, 16'h0000, 0);
    endtask

    task automatic test_patterns();
        logic [AW-1:0] addrs [5];
        addrs = '{8'd0, 8'd1, 8'd199, 8'd100, 8'd42};
        for (int i = 0; i < 5; i++) begin
            run_txn(0, 1'b1, addrs[i], 16'($urandom), 0);
        end
        for (int i = 4; i >= 0; i--) begin
            run_txn(0, 1'b0, addrs[i], 16'h0000, 0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            run_txn(0, 1'b1, 8'(50 + i), 16'(16'h1000 + i), 0);
            run_txn(0, 1'b0, 8'(50 + i), 16'h0000, 0);
            run_txn(0, 1'b1, 8'(50 + i), 16'(16'hA000 ^ i), 0);
            run_txn(0, 1'b0, 8'(50 + i), 16'h0000, 0);
        end
    endtask

    task automatic test_backpressure();
        run_txn(0, 1'b1, 8'd9, 16'h0990, 0);
        run_txn(0, 1'b0, 8'd9, 16'h0000, 5);
        run_txn(0, 1'b0, 8'd9, 16'h0000, 0);
    endtask

    task automatic test_out_of_range();
        run_txn(0, 1'b1, 8'd219, 16'h5A5A, 0);
        run_txn(0, 1'b1, 8'd220, 16'hFFFF, 0);
        run_txn(0, 1'b0, 8'd220, 16'h0000, 0);
        run_txn(0, 1'b0, 8'd219, 16'h0000, 0);
    endtask

    task automatic test_reset_mid();
        int stray;
        run_txn(0, 1'b1, 8'd7, 16'h1234, 0);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 8'd7;
        req_wdata[0] = 16'hFFFF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state busy=%b valid=%b ready=%b required 0/0/0",
                     busy[0], rsp_valid[0], req_ready[0]);
        end
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL stray_rsp_valid got=%0d cycles required 0", stray);
        end
        $display("txn reset during WAIT of store addr=7");
        run_txn(0, 1'b0, 8'd7, 16'h0000, 0);
    endtask

    task automatic test_zero_wait();
        run_txn(1, 1'b1, 8'd2, 16'h1111, 0);
        run_txn(1, 1'b0, 8'd2, 16'h0000, 0);
        run_txn(1, 1'b1, 8'd255, 16'h2222, 0);
        run_txn(1, 1'b0, 8'd2, 16'h0000, 0);
    endtask

    task automatic test_parity();
        run_txn(0, 1'b1, 8'd3, 16'h00F0, 0);
        dut.u_array.mem[3][0] = ~dut.u_array.mem[3][0];
        model_mem[0][3] = model_mem[0][3] ^ 16'h0001;
        model_bad[0][3] = 1'b1;
        run_txn(0, 1'b0, 8'd3, 16'h0000, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_patterns();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        test_zero_wait();
        test_parity();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
